// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types, lamp encodings and keypad codes for the phase controller.
package traffic_pkg;
   typedef enum logic [1:0] {S_GREEN = 2'b00, S_YELLOW = 2'b01, S_CLEAR = 2'b10} phase_state_t;
   typedef enum logic [2:0] {P_IDLE, P_SEL, P_TENS, P_UNITS, P_WAIT_COMMIT} prog_state_t;
   localparam logic [2:0] LAMP_RED = 3'b100, LAMP_YELLOW = 3'b010, LAMP_GREEN = 3'b001;
   localparam logic [1:0] PED_DONT_WALK = 2'b10, PED_WALK = 2'b01;
   localparam logic [3:0] KEY_CANCEL = 4'hA, KEY_COMMIT = 4'hB;
endpackage

// File: rtl/traffic_phase_controller_if.sv
// traffic_phase_controller_if: keypad, tick and lamp/status bundle; ped_req exists only with PED_REQUEST_EN.
interface traffic_phase_controller_if #(parameter int NUM_PHASES = 2, parameter int TIME_W = 7);
   logic                              i_tick;
   logic                              i_dav;
   logic [3:0]                        i_key_data;
`ifdef PED_REQUEST_EN
   logic [NUM_PHASES-1:0]             i_ped_req;
`endif
   logic [3*NUM_PHASES-1:0]           o_road_light;
   logic [2*NUM_PHASES-1:0]           o_ped_light;
   logic [$clog2(NUM_PHASES)-1:0]     o_active_phase;
   logic [1:0]                        o_state_flag;
   logic [TIME_W-1:0]                 o_time_remaining;
   logic                              o_prog_busy;
   logic                              o_prog_done;
   logic                              o_prog_err;
   modport master (
`ifdef PED_REQUEST_EN
      output i_ped_req,
`endif
      output i_tick, i_dav, i_key_data,
      input  o_road_light, o_ped_light, o_active_phase, o_state_flag, o_time_remaining,
      input  o_prog_busy, o_prog_done, o_prog_err
   );
   modport slave (
`ifdef PED_REQUEST_EN
      input  i_ped_req,
`endif
      input  i_tick, i_dav, i_key_data,
      output o_road_light, o_ped_light, o_active_phase, o_state_flag, o_time_remaining,
      output o_prog_busy, o_prog_done, o_prog_err
   );
endinterface

// File: rtl/keypad_time_programmer.sv
// keypad_time_programmer: keypad entry FSM (select, tens, units, commit) owning the green/yellow duration registers.
module keypad_time_programmer
   import traffic_pkg::*;
#(
   parameter int NUM_PHASES     = 2,
   parameter int TIME_W         = 7,
   parameter int GREEN_DEFAULT  = 20,
   parameter int YELLOW_DEFAULT = 3
) (
   input  logic                                i_clock,
   input  logic                                i_reset_n,
   input  logic                                i_dav,
   input  logic [3:0]                          i_key_data,
   output logic [NUM_PHASES-1:0][TIME_W-1:0]   o_green,
   output logic [TIME_W-1:0]                   o_yellow,
   output logic                                o_busy,
   output logic                                o_done,
   output logic                                o_err
);
   localparam logic [3:0] SEL_MAX = 4'(NUM_PHASES);
   prog_state_t r_state, w_next;
   logic [3:0] r_sel, r_tens, r_units;
   logic [NUM_PHASES-1:0][TIME_W-1:0] r_green;
   logic [TIME_W-1:0] r_yellow, w_value;
   logic r_done, r_err, w_wr, w_err, w_digit;
   assign w_digit = i_key_data <= 4'd9;
   assign w_value = TIME_W'(r_tens) * TIME_W'(10) + TIME_W'(r_units);
   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) begin
         r_state  <= P_IDLE;
         r_sel    <= '0;
         r_tens   <= '0;
         r_units  <= '0;
         r_green  <= {NUM_PHASES{TIME_W'(GREEN_DEFAULT)}};
         r_yellow <= TIME_W'(YELLOW_DEFAULT);
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_wr;
         r_err   <= w_err;
         if (i_dav && w_digit && r_state == P_IDLE) r_sel <= i_key_data;
         if (i_dav && w_digit && r_state == P_TENS) r_tens <= i_key_data;
         if (i_dav && w_digit && r_state == P_UNITS) r_units <= i_key_data;
         if (w_wr && r_sel == SEL_MAX) r_yellow <= w_value;
         for (int k = 0; k < NUM_PHASES; k++)
            if (w_wr && r_sel == 4'(k)) r_green[k] <= w_value;
      end
   // P_SEL is never held: the selecting digit moves IDLE straight to awaiting tens
   always_comb begin
      w_next = r_state;
      w_wr   = 1'b0;
      w_err  = 1'b0;
      if (i_dav && i_key_data == KEY_CANCEL)
         w_next = P_IDLE;
      else if (i_dav && i_key_data == KEY_COMMIT) begin
         w_next = P_IDLE;
         w_wr   = r_state == P_WAIT_COMMIT && w_value != '0;
         w_err  = !w_wr;
      end else if (i_dav && w_digit) begin
         w_err  = r_state == P_WAIT_COMMIT || (r_state == P_IDLE && i_key_data > SEL_MAX);
         w_next = w_err ? P_IDLE : r_state == P_IDLE ? P_TENS : r_state == P_TENS ? P_UNITS : P_WAIT_COMMIT;
      end
   end
   always_comb begin
      o_busy   = r_state != P_IDLE;
      o_done   = r_done;
      o_err    = r_err;
      o_green  = r_green;
      o_yellow = r_yellow;
   end
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: N-phase green/yellow/clear sequencer with run-time keypad timing.
// Optional PED_REQUEST_EN: walk lamps granted only on latched pedestrian requests.
module traffic_phase_controller
   import traffic_pkg::*;
#(
   parameter int NUM_PHASES     = 2,
   parameter int TIME_W         = 7,
   parameter int GREEN_DEFAULT  = 20,
   parameter int YELLOW_DEFAULT = 3,
   parameter int CLEAR_TIME     = 1
) (
   input logic                      i_clock,
   input logic                      i_reset_n,
   traffic_phase_controller_if.slave bus
);
   localparam int PW = $clog2(NUM_PHASES);
   localparam logic [3*NUM_PHASES-1:0] ROAD_RESET = {{(NUM_PHASES-1){LAMP_RED}}, LAMP_GREEN};
`ifdef PED_REQUEST_EN
   localparam logic [2*NUM_PHASES-1:0] PED_RESET = {NUM_PHASES{PED_DONT_WALK}};
`else
   localparam logic [2*NUM_PHASES-1:0] PED_RESET = {{(NUM_PHASES-1){PED_DONT_WALK}}, PED_WALK};
`endif
   logic [NUM_PHASES-1:0][TIME_W-1:0] w_green;
   logic [TIME_W-1:0] w_yellow, r_time, w_time;
   phase_state_t r_state, w_state;
   logic [PW-1:0] r_phase, w_phase;
   logic [3*NUM_PHASES-1:0] r_road, w_road;
   logic [2*NUM_PHASES-1:0] r_ped, w_ped;
   logic w_enter, w_grant;
   keypad_time_programmer #(
      .NUM_PHASES(NUM_PHASES), .TIME_W(TIME_W),
      .GREEN_DEFAULT(GREEN_DEFAULT), .YELLOW_DEFAULT(YELLOW_DEFAULT)
   ) u_prog (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .i_dav(bus.i_dav), .i_key_data(bus.i_key_data),
      .o_green(w_green), .o_yellow(w_yellow),
      .o_busy(bus.o_prog_busy), .o_done(bus.o_prog_done), .o_err(bus.o_prog_err)
   );
   assign w_enter = bus.i_tick && r_time == TIME_W'(1) && r_state == S_CLEAR;
`ifdef PED_REQUEST_EN
   logic [NUM_PHASES-1:0] r_latch, w_req;
   logic r_grant;
   assign w_req   = r_latch | bus.i_ped_req;
   assign w_grant = w_enter ? w_req[w_phase] : r_grant;
   // a request seen on the green-entry cycle is consumed by that green
   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) begin
         r_latch <= '0;
         r_grant <= 1'b0;
      end else begin
         r_latch <= w_enter ? w_req & ~(NUM_PHASES'(1) << w_phase) : w_req;
         r_grant <= w_grant;
      end
`else
   assign w_grant = 1'b1;
`endif
   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) begin
         r_state <= S_GREEN;
         r_phase <= '0;
         r_time  <= TIME_W'(GREEN_DEFAULT);
         r_road  <= ROAD_RESET;
         r_ped   <= PED_RESET;
      end else begin
         r_state <= w_state;
         r_phase <= w_phase;
         r_time  <= w_time;
         r_road  <= w_road;
         r_ped   <= w_ped;
      end
   // durations are sampled only here, so a commit never alters a running state
   always_comb begin
      w_state = r_state;
      w_phase = r_phase;
      w_time  = r_time;
      if (bus.i_tick && r_time != TIME_W'(1))
         w_time = r_time - 1'b1;
      else if (bus.i_tick) begin
         w_state = r_state == S_GREEN ? S_YELLOW : r_state == S_YELLOW ? S_CLEAR : S_GREEN;
         w_phase = r_state != S_CLEAR ? r_phase : r_phase == PW'(NUM_PHASES-1) ? '0 : r_phase + 1'b1;
         w_time  = w_state == S_YELLOW ? w_yellow : w_state == S_CLEAR ? TIME_W'(CLEAR_TIME) : w_green[w_phase];
      end
   end
   always_comb begin
      w_road = '0;
      w_ped  = '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         w_road[3*k +: 3] = PW'(k) != w_phase ? LAMP_RED : w_state == S_GREEN ? LAMP_GREEN :
                            w_state == S_YELLOW ? LAMP_YELLOW : LAMP_RED;
         w_ped[2*k +: 2]  = PW'(k) == w_phase && w_state == S_GREEN && w_grant ? PED_WALK : PED_DONT_WALK;
      end
   end
   assign bus.o_road_light     = r_road;
   assign bus.o_ped_light      = r_ped;
   assign bus.o_active_phase   = r_phase;
   assign bus.o_state_flag     = r_state;
   assign bus.o_time_remaining = r_time;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: random tick/keypad stimulus against a behavioural intersection model.
module tb_traffic_phase_controller;
   localparam int NP = 3;
   localparam int TW = 7;
   localparam int CLR = 1;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_pass = 0, n_total = 0;
   traffic_phase_controller_if #(.NUM_PHASES(NP), .TIME_W(TW)) bus ();
   traffic_phase_controller #(
      .NUM_PHASES(NP), .TIME_W(TW), .GREEN_DEFAULT(20), .YELLOW_DEFAULT(3), .CLEAR_TIME(CLR)
   ) dut (.i_clock(clk), .i_reset_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // model: phase index, state 0/1/2 = green/yellow/clear, seconds left, and the raw key buffer
   int m_phase, m_st, m_left, m_yel;
   int m_green[NP];
   int m_buf[$];
   bit m_done, m_err, m_grant;
   bit [NP-1:0] m_latch, m_req;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_st = 0; m_left = 20; m_yel = 3;
         foreach (m_green[i]) m_green[i] = 20;
         m_buf.delete();
         m_done = 0; m_err = 0; m_grant = 0; m_latch = '0;
      end else begin
         m_done = 0; m_err = 0;
`ifdef PED_REQUEST_EN
         m_req = m_latch | bus.i_ped_req;
`else
         m_req = '0;
`endif
         if (bus.i_tick) begin
            if (m_left > 1) m_left--;
            else if (m_st == 0) begin m_st = 1; m_left = m_yel; end
            else if (m_st == 1) begin m_st = 2; m_left = CLR; end
            else begin
               m_phase = (m_phase + 1) % NP; m_st = 0; m_left = m_green[m_phase];
               m_grant = m_req[m_phase]; m_req[m_phase] = 1'b0;
            end
         end
         m_latch = m_req;
         if (bus.i_dav) begin
            int k;
            k = int'(bus.i_key_data);
            if (k == 10) m_buf.delete();
            else if (k == 11) begin
               if (m_buf.size() == 3 && m_buf[1] * 10 + m_buf[2] != 0) begin
                  if (m_buf[0] == NP) m_yel = m_buf[1] * 10 + m_buf[2];
                  else m_green[m_buf[0]] = m_buf[1] * 10 + m_buf[2];
                  m_done = 1;
               end else m_err = 1;
               m_buf.delete();
            end else if (k < 10) begin
               if (m_buf.size() == 3 || (m_buf.size() == 0 && k > NP)) begin
                  m_err = 1; m_buf.delete();
               end else m_buf.push_back(k);
            end
         end
      end
   end
   always @(negedge clk) if (rst_n) begin
      logic [3*NP-1:0] e_road;
      logic [2*NP-1:0] e_ped;
      for (int p = 0; p < NP; p++) begin
         e_road[3*p +: 3] = (p == m_phase && m_st == 0) ? 3'b001 : (p == m_phase && m_st == 1) ? 3'b010 : 3'b100;
`ifdef PED_REQUEST_EN
         e_ped[2*p +: 2] = (p == m_phase && m_st == 0 && m_grant) ? 2'b01 : 2'b10;
`else
         e_ped[2*p +: 2] = (p == m_phase && m_st == 0) ? 2'b01 : 2'b10;
`endif
      end
      check("road_light", 32'(bus.o_road_light), 32'(e_road));
      check("ped_light", 32'(bus.o_ped_light), 32'(e_ped));
      check("active_phase", 32'(bus.o_active_phase), m_phase);
      check("state_flag", 32'(bus.o_state_flag), m_st);
      check("time_remaining", 32'(bus.o_time_remaining), m_left);
      check("prog_busy", 32'(bus.o_prog_busy), 32'(m_buf.size() != 0));
      check("prog_done", 32'(bus.o_prog_done), 32'(m_done));
      check("prog_err", 32'(bus.o_prog_err), 32'(m_err));
   end
   task automatic do_ticks(input int n);
      repeat (n) begin
         bus.i_tick = 1'b1; @(posedge clk); #1;
         bus.i_tick = 1'b0; @(posedge clk); #1;
      end
   endtask
   task automatic send_key(input logic [3:0] k);
      bus.i_dav = 1'b1; bus.i_key_data = k; @(posedge clk); #1;
      bus.i_dav = 1'b0;
   endtask
   initial begin
      int r;
      bus.i_tick = 1'b0; bus.i_dav = 1'b0; bus.i_key_data = '0;
`ifdef PED_REQUEST_EN
      bus.i_ped_req = '0;
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset time", 32'(bus.o_time_remaining), 20);
      check("reset road", 32'(bus.o_road_light), 32'(9'b100_100_001));
`ifdef PED_REQUEST_EN
      check("reset ped", 32'(bus.o_ped_light), 32'(6'b10_10_10));
      bus.i_ped_req = 3'b010; @(posedge clk); #1 bus.i_ped_req = '0;
`else
      check("reset ped", 32'(bus.o_ped_light), 32'(6'b10_10_01));
`endif
      do_ticks(5);
      send_key(4'd1); send_key(4'd0); send_key(4'd5); send_key(4'hB);
      check("commit green1 done", 32'(bus.o_prog_done), 1);
      check("phase0 unchanged", 32'(bus.o_time_remaining), 15);
      do_ticks(19);
      check("tick24 phase", 32'(bus.o_active_phase), 1);
      check("tick24 green", 32'(bus.o_state_flag), 0);
      check("phase1 green 5", 32'(bus.o_time_remaining), 5);
      check("phase1 ped walk", 32'(bus.o_ped_light), 32'(6'b10_01_10));
      send_key(4'd3); send_key(4'd0); send_key(4'd4); send_key(4'hB);
      check("commit yellow done", 32'(bus.o_prog_done), 1);
      do_ticks(5);
      check("phase1 yellow", 32'(bus.o_state_flag), 1);
      check("yellow 4", 32'(bus.o_time_remaining), 4);
      check("yellow road", 32'(bus.o_road_light), 32'(9'b100_010_100));
      send_key(4'd0); send_key(4'd1);
      check("entry pending", 32'(bus.o_prog_busy), 1);
      rst_n = 1'b0; #1;
      check("async rst time", 32'(bus.o_time_remaining), 20);
      check("async rst phase", 32'(bus.o_active_phase), 0);
      check("async rst flag", 32'(bus.o_state_flag), 0);
      check("async rst busy", 32'(bus.o_prog_busy), 0);
      check("async rst road", 32'(bus.o_road_light), 32'(9'b100_100_001));
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send_key(4'd4);
      check("bad select err", 32'(bus.o_prog_err), 1);
      send_key(4'd0); send_key(4'd0); send_key(4'd0); send_key(4'hB);
      check("zero commit err", 32'(bus.o_prog_err), 1);
      send_key(4'd0); send_key(4'd1); send_key(4'hA);
      check("cancel idle", 32'(bus.o_prog_busy), 0);
      check("cancel no err", 32'(bus.o_prog_err), 0);
      check("cancel no done", 32'(bus.o_prog_done), 0);
      send_key(4'hB);
      check("early commit err", 32'(bus.o_prog_err), 1);
      repeat (4000) begin
         r = $urandom_range(0, 9);
         bus.i_tick = $urandom_range(0, 3) == 0;
         bus.i_dav = $urandom_range(0, 2) == 0;
         bus.i_key_data = r < 2 ? 4'hB : r == 2 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, r < 6 ? 4 : 9));
`ifdef PED_REQUEST_EN
         bus.i_ped_req = $urandom_range(0, 7) == 0 ? 3'($urandom_range(0, 7)) : 3'b000;
`endif
         @(posedge clk); #1;
      end
      bus.i_tick = 1'b0; bus.i_dav = 1'b0;
      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised N-phase traffic intersection controller, successor to the fixed two-road principal/secondary controller. Sequences every phase through green, yellow and all-red clearance on a 1 Hz tick enable, drives per-phase road and pedestrian lamps, and exports time-remaining and state for the LCD output path. Per-phase green times and the shared yellow time are reprogrammed at run time from the keypad data/dav stream without stopping the intersection.

## Interface
- NUM_PHASES, 2: number of phases, range 2..8.
- TIME_W, 7: width of all time values in seconds, max 99.
- GREEN_DEFAULT, 20: green time of every phase after reset.
- YELLOW_DEFAULT, 3: yellow time after reset.
- CLEAR_TIME, 1: all-red clearance time, fixed, ≥1.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle 1 Hz enable, synchronous to clock.
- dav  in  1  one-cycle keypad data-valid pulse.
- key_data  in  4  keypad code: 0x0-0x9 digits, 0xA cancel, 0xB commit, 0xC-0xF ignored.
- ped_req  in  NUM_PHASES  pedestrian request pulses, one per phase (PED_REQUEST_EN only).
- road_light  out  3*NUM_PHASES  per phase {red,yellow,green}, one-hot.
- ped_light  out  2*NUM_PHASES  per phase {dont_walk,walk}, one-hot.
- active_phase  out  $clog2(NUM_PHASES)  phase currently owning right of way.
- state_flag  out  2  00 GREEN, 01 YELLOW, 10 CLEAR.
- time_remaining  out  TIME_W  seconds left in current state.
- prog_busy  out  1  entry in progress.
- prog_done / prog_err  out  1  one-cycle pulses on commit accepted / rejected.

## Operation
- FSM per active phase p: GREEN → YELLOW → CLEAR → GREEN of (p+1) mod NUM_PHASES.
- On state entry time_remaining loads that state's duration. On tick: if time_remaining==1 advance and load next duration, else decrement. Each state lasts exactly its duration in ticks.
- Phase p: green/yellow lamp in GREEN/YELLOW of p; all other phases red; every phase red in CLEAR.
- ped_light[p] walk only during GREEN of p; dont_walk otherwise.
- Programming sub-FSM IDLE → SEL → TENS → UNITS → WAIT_COMMIT. First digit selects target: 0..NUM_PHASES-1 = that phase's green, NUM_PHASES = yellow, larger → prog_err, back to IDLE. Then tens digit, units digit, then 0xB commits.
- Commit with value 0 → prog_err, no write. 0xA in any state → IDLE, no pulse. Digit in WAIT_COMMIT or 0xB before WAIT_COMMIT → prog_err, IDLE.
- New durations take effect at the next load of that state, never mid-state. Commit and load in same cycle: load uses old value.
- tick and dav in same cycle are handled independently.

## Timing
- Reset values: active_phase 0, state GREEN, time_remaining GREEN_DEFAULT, road_light phase0 green / rest red, ped_light phase0 walk (without macro) else all dont_walk, prog FSM IDLE, all pulses 0, registers at defaults.
- All outputs registered; lamp and time changes visible the cycle after the tick.
- prog_done/prog_err one cycle after the committing/offending dav.
- Reset mid-entry or mid-state discards everything immediately (asynchronous).

## Configuration
- PED_REQUEST_EN defined: ped_req port present; pulses set per-phase latch; on entry to GREEN of p with latch set, walk granted for that green and latch cleared; otherwise dont_walk stays. Request during own GREEN latches for next cycle of that phase.
- Undefined: no ped_req port, walk every GREEN.

## Structure
- Package traffic_pkg: state enum (GREEN/YELLOW/CLEAR), programming-state enum, lamp encodings, key codes KEY_CANCEL=0xA, KEY_COMMIT=0xB.
- Sub-module keypad_time_programmer: programming FSM plus green/yellow registers; phase FSM stays in top.

## Test plan
- Reset, NUM_PHASES=3, 30 ticks → phase0 green 20, yellow 3, clear 1, phase1 green at tick 24.
- Keys 1,0,5,0xB mid-phase0 green → prog_done; phase0 duration unchanged; phase1 green lasts 5 ticks.
- Keys 3,0,4,0xB (NUM_PHASES=3) → yellow=4 on next yellow; keys 4,… → prog_err.
- Keys 0,0,0,0xB → prog_err, no change; keys 0,1,0xA → IDLE, no pulse.
- PED_REQUEST_EN: ped_req[1] during phase0 → walk in phase1 green only; no request → dont_walk for phase2.
- Reset asserted mid-YELLOW of phase1 with entry pending → reset values above.
